// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
//   Shared constants and the arbiter state encoding for the cache/memory
//   arbiter. Block geometry is fixed here so the top, the counter sub-module
//   and the bench all agree on it.
package cache_mem_arbiter_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LATENCY     = 4;

  // Word index width within a block, and byte-offset width of a block
  // (16-bit words, so one extra byte-select bit).
  localparam int OFFSET_W   = $clog2(WORDS_PER_BLOCK);
  localparam int BYTE_OFF_W = OFFSET_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DWRITE = 2'b01,
    DFILL  = 2'b10,
    IFILL  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//   Single-ported pipelined main-memory bus.
//   master : arbiter side (drives enable/wr/addr/wdata, receives read data)
//   slave  : memory side
//   mem_enable     access this cycle
//   mem_wr         1 = write, 0 = read
//   mem_addr       byte address
//   mem_wdata      write data
//   mem_data_in    read data returned by memory
//   mem_data_valid mem_data_in valid
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;

  modport master (
    output mem_enable, mem_wr, mem_addr, mem_wdata,
    input  mem_data_in, mem_data_valid
  );

  modport slave (
    input  mem_enable, mem_wr, mem_addr, mem_wdata,
    output mem_data_in, mem_data_valid
  );

endinterface

// File: rtl/cache_mem_arbiter_fill_counter.sv
// cache_mem_arbiter_fill_counter
//   Issue/receive counter pair for one block fill.
//   clk, rst  clock, synchronous active-high reset
//   clr       clear both counters (held while no fill is active)
//   iss_inc   advance issue counter (saturates once all reads are issued)
//   rcv_inc   advance receive counter (one per returned word)
//   iss_idx   word index of the next read to issue
//   iss_done  all reads of the block have been issued
//   rcv       word index of the next returned word
//   rcv_last  next returned word is the last of the block
module cache_mem_arbiter_fill_counter
  import cache_mem_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                iss_inc,
  input  logic                rcv_inc,
  output logic [OFFSET_W-1:0] iss_idx,
  output logic                iss_done,
  output logic [OFFSET_W-1:0] rcv,
  output logic                rcv_last
);

  // One extra bit so the count can reach WORDS_PER_BLOCK and stop there.
  logic [OFFSET_W:0] iss;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      iss <= '0;
      rcv <= '0;
    end else begin
      if (iss_inc && !iss_done) iss <= iss + 1'b1;
      if (rcv_inc)              rcv <= rcv + 1'b1;
    end
  end

  assign iss_idx  = iss[OFFSET_W-1:0];
  assign iss_done = iss[OFFSET_W];
  assign rcv_last = &rcv;

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one pipelined main memory between the I-cache miss path and the
//   D-cache miss / write-through path. Priority: D-write > D-fill > I-fill.
//   Fills issue WORDS_PER_BLOCK back-to-back reads and stream the returned
//   words into the requesting cache; fills are never preempted.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     icache_miss/_miss_addr         I-cache block request (level)
//     icache_fill_we/_word/_done     I-cache fill write strobe, index, last
//     dcache_miss/_miss_addr         D-cache block request (level)
//     dcache_wr_req/_addr/_data      D-cache write-through store
//     dcache_wr_ack                  store issued this cycle
//     dcache_fill_we/_word/_done     D-cache fill write strobe, index, last
//     fill_data                      returned word, shared by both caches
//     mem                            memory bus (master side)
//
//   state  | meaning
//   IDLE   | no access; grant evaluated each cycle
//   DWRITE | single-cycle write-through store on the bus
//   DFILL  | D-cache block fill in progress
//   IFILL  | I-cache block fill in progress
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icache_miss,
  input  logic [ADDR_W-1:0]   icache_miss_addr,
  output logic                icache_fill_we,
  output logic [OFFSET_W-1:0] icache_fill_word,
  output logic                icache_fill_done,
  input  logic                dcache_miss,
  input  logic [ADDR_W-1:0]   dcache_miss_addr,
  input  logic                dcache_wr_req,
  input  logic [ADDR_W-1:0]   dcache_wr_addr,
  input  logic [DATA_W-1:0]   dcache_wr_data,
  output logic                dcache_wr_ack,
  output logic                dcache_fill_we,
  output logic [OFFSET_W-1:0] dcache_fill_word,
  output logic                dcache_fill_done,
  output logic [DATA_W-1:0]   fill_data,
  cache_mem_arbiter_if.master mem
);

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BYTE_OFF_W) - 1);

  arb_state_t          state, state_d;
  logic [ADDR_W-1:0]   blk_q, blk_d;
  logic                blk_load;
  logic                cnt_clr, iss_inc, rcv_inc;
  logic [OFFSET_W-1:0] iss_idx, rcv;
  logic                iss_done, rcv_last;

  cache_mem_arbiter_fill_counter u_fill_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .iss_inc  (iss_inc),
    .rcv_inc  (rcv_inc),
    .iss_idx  (iss_idx),
    .iss_done (iss_done),
    .rcv      (rcv),
    .rcv_last (rcv_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      blk_q <= '0;
    end else begin
      state <= state_d;
      if (blk_load) blk_q <= blk_d;
    end
  end

  always_comb begin
    state_d          = state;
    blk_load         = 1'b0;
    blk_d            = blk_q;
    cnt_clr          = 1'b1;
    iss_inc          = 1'b0;
    rcv_inc          = 1'b0;
    mem.mem_enable   = 1'b0;
    mem.mem_wr       = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_wdata    = '0;
    dcache_wr_ack    = 1'b0;
    icache_fill_we   = 1'b0;
    icache_fill_word = '0;
    icache_fill_done = 1'b0;
    dcache_fill_we   = 1'b0;
    dcache_fill_word = '0;
    dcache_fill_done = 1'b0;

    unique case (state)
      IDLE: begin
        // Returns arriving here (after a reset mid-fill) are dropped.
        if (dcache_wr_req) begin
          state_d = DWRITE;
        end else if (dcache_miss) begin
          state_d  = DFILL;
          blk_load = 1'b1;
          blk_d    = dcache_miss_addr & BLK_MASK;
        end else if (icache_miss) begin
          state_d  = IFILL;
          blk_load = 1'b1;
          blk_d    = icache_miss_addr & BLK_MASK;
        end
      end

      DWRITE: begin
        mem.mem_enable = 1'b1;
        mem.mem_wr     = 1'b1;
        mem.mem_addr   = dcache_wr_addr;
        mem.mem_wdata  = dcache_wr_data;
        dcache_wr_ack  = 1'b1;
        state_d        = IDLE;
      end

      DFILL, IFILL: begin
        cnt_clr = 1'b0;
        if (!iss_done) begin
          mem.mem_enable = 1'b1;
          mem.mem_addr   = blk_q | ADDR_W'({iss_idx, 1'b0});
          iss_inc        = 1'b1;
        end
        if (mem.mem_data_valid) begin
          rcv_inc = 1'b1;
          if (state == DFILL) begin
            dcache_fill_we   = 1'b1;
            dcache_fill_word = rcv;
            dcache_fill_done = rcv_last;
          end else begin
            icache_fill_we   = 1'b1;
            icache_fill_word = rcv;
            icache_fill_done = rcv_last;
          end
          if (rcv_last) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign fill_data = mem.mem_data_in;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one single-ported, pipelined, multi-cycle main memory between the I-cache miss path and the D-cache miss/write-through path of the 5-stage CPU.
- Sequences block fills: issues WORDS_PER_BLOCK consecutive word reads, then streams the returned words into the requesting cache's data array.
- Forwards single-word D-cache write-through stores.
- Priority: D-write > D-fill > I-fill.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLOCK, 8, words per cache block (power of 2)
- MEM_LATENCY, 4, cycles from read issue to mem_data_valid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- icache_miss  in  1  level; held until icache_fill_done
- icache_miss_addr  in  ADDR_W  missing address
- icache_fill_we  out  1  write returned word into I-cache
- icache_fill_word  out  3  word index within block
- icache_fill_done  out  1  one-cycle pulse, last word
- dcache_miss  in  1  level; held until dcache_fill_done
- dcache_miss_addr  in  ADDR_W  missing address
- dcache_wr_req  in  1  write-through store request
- dcache_wr_addr  in  ADDR_W  store address
- dcache_wr_data  in  DATA_W  store data
- dcache_wr_ack  out  1  one-cycle pulse, store issued
- dcache_fill_we  out  1  write returned word into D-cache
- dcache_fill_word  out  3  word index within block
- dcache_fill_done  out  1  one-cycle pulse, last word
- fill_data  out  DATA_W  returned word (shared by both caches; equals mem_data_in)
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_data_in  in  DATA_W  memory read data
- mem_data_valid  in  1  mem_data_in valid

Behaviour:
- Reset: state IDLE; counters 0; latched address 0; every output 0.
- States: IDLE, DWRITE, DFILL, IFILL.
- IDLE grant, evaluated each cycle:
  - dcache_wr_req -> DWRITE
  - else dcache_miss -> DFILL
  - else icache_miss -> IFILL
  - The block address {addr[15:4], 4'b0} is latched at grant.
- DWRITE: exactly one cycle.
  - mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data.
  - dcache_wr_ack=1 in the same cycle.
  - Next state IDLE.
- DFILL / IFILL:
  - Issue counter iss (0..8): while iss<8, drive mem_enable=1, mem_wr=0, mem_addr={blk[15:4], iss[2:0], 1'b0}; iss increments each cycle, giving 8 back-to-back reads.
  - Receive counter rcv (0..7): on each mem_data_valid, assert the active cache's fill_we with fill_word=rcv, then rcv increments.
  - The cycle with mem_data_valid and rcv==7 asserts fill_done together with the last fill_we; the FSM returns to IDLE on the next edge and clears both counters.
- Latency: request seen in IDLE at cycle 0. Reads are issued cycles 1-8. Fill writes occur cycles 1+MEM_LATENCY through 8+MEM_LATENCY. With the default latency, done is at cycle 12.
- Fills are non-preemptible. A D-write or D-miss arriving during IFILL waits until IDLE. A D-write arriving during DFILL also waits.
- A requester dropping its miss mid-fill does not abort the fill; the block completes and done still pulses.
- mem_data_valid in IDLE or DWRITE is ignored: no fill_we is asserted.
- Back-to-back requests: after done, one IDLE cycle always precedes the next grant.
- Simultaneous I-miss and D-miss: D is served first; I is granted in the IDLE cycle after dcache_fill_done.
- Reset mid-fill: immediate return to IDLE, counters cleared, no done pulse. In-flight returns are then ignored under the IDLE rule.
- fill_data is combinationally equal to mem_data_in. Only one cache's fill_we is ever high in a given cycle.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'b00, DWRITE=2'b01, DFILL=2'b10, IFILL=2'b11)
  - WORDS_PER_BLOCK, MEM_LATENCY and block-offset width constants
- One natural sub-module: fill_counter, a 3/4-bit issue/receive counter pair with clear and done detect, instantiated once.

Test Plan:
- D-miss at 0x1236 with default latency -> reads 0x1230, 0x1232, ... 0x123E on cycles 1-8; dcache_fill_we on cycles 5-12 with word 0-7; dcache_fill_done only at cycle 12.
- icache_miss and dcache_miss asserted together -> D block fill completes first; after one IDLE cycle I reads start; the two fill_we signals are never high in the same cycle.
- dcache_wr_req (addr 0x0040, data 0xBEEF) together with dcache_miss -> first cycle has mem_wr=1, addr 0x0040, wdata 0xBEEF and wr_ack=1; the D fill starts after one IDLE cycle.
- dcache_wr_req raised during IFILL -> no mem_wr until the cycle after icache_fill_done plus one IDLE cycle; then ack.
- rst asserted at cycle 6 of a D fill -> all outputs 0 the next cycle, no done pulse, later mem_data_valid pulses produce no fill_we.
- Spurious mem_data_valid in IDLE -> no fill_we or done on either cache.
